mole_controller: RTL and testbench

- Game-round sequencer for the whack-a-mole core.
- Sits directly downstream of the interval counter and consumes its terminal-count output as the round tick.
- On each tick it lights one pseudo-randomly chosen mole, then judges player button presses against it.
- Keeps score and miss count, and declares game over after too many misses.

---
 rtl/mole_controller_pkg.sv | 25 ++
 rtl/mole_controller_if.sv | 20 ++
 rtl/mole_controller_btn_sync_edge.sv | 25 ++
 rtl/mole_controller.sv | 130 +++++++++++++
 tb/tb_mole_controller.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mole_controller_pkg.sv
// Shared types and helpers for the whack-a-mole round sequencer (package whack_pkg).
package whack_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, UP, OVER} state_t;

  localparam int unsigned LFSR_W = 8;
  // Fibonacci taps 8,6,5,4 as a mask over lfsr[7:0]
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
  localparam int N_MOLES_DEF = 4;

  // Fold a raw 3-bit index into 0..n-1 by repeated subtraction
  function automatic logic [2:0] wrap_idx(input logic [2:0] raw, input int unsigned n);
    logic [2:0] v;
    v = raw;
    for (int unsigned i = 0; i < 8; i++) begin
      if (32'(v) >= n) v = v - 3'(n);
    end
    return v;
  endfunction

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

endpackage

// File: rtl/mole_controller_if.sv
// Game-side signal bundle for mole_controller: round inputs and score/mole outputs.
interface mole_controller_if #(
  parameter int N_MOLES = whack_pkg::N_MOLES_DEF,
  parameter int SCORE_W = 8
);
  logic               start;
  logic               tick;
  logic [N_MOLES-1:0] btn;
  logic [N_MOLES-1:0] mole;
  logic [SCORE_W-1:0] score;
  logic [2:0]         misses;
  logic               game_over;
  logic               hit_pulse;
  logic               miss_pulse;

  modport master (output start, tick, btn,
                  input  mole, score, misses, game_over, hit_pulse, miss_pulse);
  modport slave  (input  start, tick, btn,
                  output mole, score, misses, game_over, hit_pulse, miss_pulse);
endinterface

// File: rtl/mole_controller_btn_sync_edge.sv
// Two-flop synchroniser per bit followed by a registered rising-edge detector.
module btn_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);
  logic [W-1:0] s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      s3   <= '0;
      rise <= '0;
    end else begin
      s1   <= d;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
    end
  end
endmodule

// File: rtl/mole_controller.sv
// Whack-a-mole round sequencer: lights a pseudo-random mole per tick, judges presses, scores.
// Optional MOLE_NO_REPEAT_EN forbids lighting the same mole twice in a row.
module mole_controller
  import whack_pkg::*;
#(
  parameter int                N_MOLES    = N_MOLES_DEF,
  parameter int                SCORE_W    = 8,
  parameter int                MAX_MISSES = 3,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 8'hA5
) (
  input  logic           clk,
  input  logic           rst_n,
  mole_controller_if.slave bus
);
  state_t             state, state_n;
  logic [N_MOLES-1:0] mole_q, mole_n, mole_pick, btn_rise;
  logic [SCORE_W-1:0] score_q, score_n;
  logic [2:0]         misses_q, misses_n, misses_inc, idx, pick;
  logic               hit_q, hit_n, miss_q, miss_n, tick_q, tick_rise, hit;
  logic [LFSR_W-1:0]  lfsr;
  logic [7:0]         oh8;
`ifdef MOLE_NO_REPEAT_EN
  logic [2:0]         last_q, last_n;
`endif

  btn_sync_edge #(.W(N_MOLES)) u_btn (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.btn),
    .rise (btn_rise)
  );

  assign tick_rise      = bus.tick & ~tick_q;
  assign hit            = |(btn_rise & mole_q);
  assign misses_inc     = misses_q + 3'd1;
  assign bus.mole       = mole_q;
  assign bus.score      = score_q;
  assign bus.misses     = misses_q;
  assign bus.game_over  = (state == OVER);
  assign bus.hit_pulse  = hit_q;
  assign bus.miss_pulse = miss_q;

  always_comb begin
    idx = wrap_idx(lfsr[2:0], N_MOLES);
    pick = idx;
`ifdef MOLE_NO_REPEAT_EN
    if (idx == last_q) pick = wrap_idx(idx + 3'd1, N_MOLES);
`endif
    oh8 = onehot(pick);
    mole_pick = oh8[N_MOLES-1:0];
  end

  always_comb begin
    state_n  = state;
    mole_n   = mole_q;
    score_n  = score_q;
    misses_n = misses_q;
    hit_n    = 1'b0;
    miss_n   = 1'b0;
`ifdef MOLE_NO_REPEAT_EN
    last_n   = last_q;
`endif
    if (bus.start) begin
      state_n  = WAIT;
      mole_n   = '0;
      score_n  = '0;
      misses_n = '0;
    end else begin
      case (state)
        IDLE: mole_n = '0;
        WAIT: if (tick_rise) begin
          mole_n  = mole_pick;
          state_n = UP;
`ifdef MOLE_NO_REPEAT_EN
          last_n  = pick;
`endif
        end
        // a hit in the same cycle as a tick edge consumes the tick
        UP: if (hit) begin
          score_n = (score_q == '1) ? score_q : score_q + 1'b1;
          hit_n   = 1'b1;
          mole_n  = '0;
          state_n = WAIT;
        end else if (tick_rise) begin
          misses_n = misses_inc;
          miss_n   = 1'b1;
          if (misses_inc == 3'(MAX_MISSES)) begin
            mole_n  = '0;
            state_n = OVER;
          end else begin
            mole_n  = mole_pick;
`ifdef MOLE_NO_REPEAT_EN
            last_n  = pick;
`endif
          end
        end
        OVER: ;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mole_q   <= '0;
      score_q  <= '0;
      misses_q <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      tick_q   <= 1'b0;
      lfsr     <= LFSR_SEED;
`ifdef MOLE_NO_REPEAT_EN
      last_q   <= '0;
`endif
    end else begin
      state    <= state_n;
      mole_q   <= mole_n;
      score_q  <= score_n;
      misses_q <= misses_n;
      hit_q    <= hit_n;
      miss_q   <= miss_n;
      tick_q   <= bus.tick;
      lfsr     <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
`ifdef MOLE_NO_REPEAT_EN
      last_q   <= last_n;
`endif
    end
  end
endmodule

// File: tb/tb_mole_controller.sv
// Scoreboard bench for mole_controller (N_MOLES=4, SCORE_W=2, MAX_MISSES=3).
module tb_mole_controller;
  localparam int NM = 4;
  localparam int SW = 2;
  localparam int MM = 3;
  localparam int SMAX = (1 << SW) - 1;

  typedef struct {
    bit is_hit;
    int score;
    int misses;
    bit over;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ev_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_score = 0;
  int   exp_misses = 0;

  always #5 clk = ~clk;

  mole_controller_if #(.N_MOLES(NM), .SCORE_W(SW)) bus ();

  mole_controller #(
    .N_MOLES(NM), .SCORE_W(SW), .MAX_MISSES(MM), .LFSR_SEED(8'hA5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulses are judged against the queued expectation at the time they appear
  always @(negedge clk) begin
    if (rst_n && (bus.hit_pulse || bus.miss_pulse)) begin : mon
      ev_t e;
      check_eq("pulse_excl", 32'(bus.hit_pulse & bus.miss_pulse), 0);
      if (sb.size() == 0) begin
        check_eq("unexpected_pulse", {30'd0, bus.hit_pulse, bus.miss_pulse}, 0);
      end else begin
        e = sb.pop_front();
        check_eq("pulse_kind", 32'(bus.hit_pulse), 32'(e.is_hit));
        check_eq("ev_score", 32'(bus.score), e.score);
        check_eq("ev_misses", 32'(bus.misses), e.misses);
        check_eq("ev_over", 32'(bus.game_over), 32'(e.over));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    exp_score = 0;
    exp_misses = 0;
  endtask

  task automatic tick_pulse(input int hold);
    @(negedge clk) bus.tick = 1'b1;
    repeat (hold) @(negedge clk);
    bus.tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic press(input logic [NM-1:0] bits);
    @(negedge clk) bus.btn = bits;
    cyc(3);
    bus.btn = '0;
    cyc(4);
  endtask

  task automatic push_ev(input bit h);
    ev_t e;
    e.is_hit = h;
    e.score = exp_score;
    e.misses = exp_misses;
    e.over = (exp_misses == MM);
    sb.push_back(e);
  endtask

  task automatic hit_lit();
    logic [NM-1:0] m;
    m = bus.mole;
    check_eq("lit_before_hit", 32'($countones(m)), 1);
    exp_score = (exp_score < SMAX) ? exp_score + 1 : SMAX;
    push_ev(1'b1);
    press(m);
  endtask

  task automatic expect_miss();
    exp_misses++;
    push_ev(1'b0);
    tick_pulse(1);
    cyc(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [NM-1:0] m, wrong, prev, cur;
    int lat;
    bus.start = 1'b0;
    bus.tick  = 1'b0;
    bus.btn   = '0;
    cyc(3);
    check_eq("rst_mole", 32'(bus.mole), 0);
    check_eq("rst_score", 32'(bus.score), 0);
    check_eq("rst_misses", 32'(bus.misses), 0);
    check_eq("rst_over", 32'(bus.game_over), 0);
    check_eq("rst_hit", 32'(bus.hit_pulse), 0);
    check_eq("rst_miss", 32'(bus.miss_pulse), 0);
    @(negedge clk) rst_n = 1'b1;
    cyc(2);

    // long tick, then a correct press with latency measurement
    do_start();
    tick_pulse(10);
    check_eq("one_lit", 32'($countones(bus.mole)), 1);
    m = bus.mole;
    exp_score = 1;
    push_ev(1'b1);
    @(negedge clk) bus.btn = m;
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(posedge clk);
      #1;
      if (bus.hit_pulse) lat = i;
    end
    check_eq("hit_latency", lat, 4);
    bus.btn = '0;
    cyc(4);
    check_eq("hit_mole_off", 32'(bus.mole), 0);
    check_eq("hit_score", 32'(bus.score), 1);

    // wrong button is ignored, the following tick is a miss and relights
    tick_pulse(1);
    m = bus.mole;
    check_eq("lit_again", 32'($countones(m)), 1);
    wrong = {m[NM-2:0], m[NM-1]};
    press(wrong);
    check_eq("wrong_score", 32'(bus.score), 1);
    check_eq("wrong_mole_held", 32'(bus.mole), 32'(m));
    expect_miss();
    check_eq("miss_count1", 32'(bus.misses), 1);
    check_eq("miss_relit", 32'($countones(bus.mole)), 1);

    // hit and tick edge land on the same clock edge
    m = bus.mole;
    exp_score = 2;
    push_ev(1'b1);
    @(negedge clk) bus.btn = m;
    cyc(3);
    bus.tick = 1'b1;
    cyc(1);
    bus.btn = '0;
    bus.tick = 1'b0;
    cyc(4);
    check_eq("align_misses", 32'(bus.misses), 1);
    check_eq("align_score", 32'(bus.score), 2);
    check_eq("align_mole_off", 32'(bus.mole), 0);

    // saturation over five hits
    do_start();
    repeat (5) begin
      tick_pulse(1);
      hit_lit();
    end
    check_eq("sat_score", 32'(bus.score), SMAX);

    // three misses end the game; later ticks and presses change nothing
    do_start();
    check_eq("start_clr_score", 32'(bus.score), 0);
    tick_pulse(1);
    check_eq("go_lit", 32'($countones(bus.mole)), 1);
    repeat (MM) expect_miss();
    check_eq("go_over", 32'(bus.game_over), 1);
    check_eq("go_mole", 32'(bus.mole), 0);
    check_eq("go_misses", 32'(bus.misses), MM);
    press('1);
    tick_pulse(1);
    cyc(2);
    check_eq("go_hold_misses", 32'(bus.misses), MM);
    check_eq("go_hold_over", 32'(bus.game_over), 1);
    check_eq("go_hold_score", 32'(bus.score), 0);

    // restart from OVER
    do_start();
    check_eq("restart_over", 32'(bus.game_over), 0);
    check_eq("restart_misses", 32'(bus.misses), 0);

    // asynchronous reset mid-game
    tick_pulse(1);
    expect_miss();
    expect_miss();
    check_eq("mid_misses", 32'(bus.misses), 2);
    check_eq("mid_lit", 32'($countones(bus.mole)), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_mole", 32'(bus.mole), 0);
    check_eq("arst_score", 32'(bus.score), 0);
    check_eq("arst_misses", 32'(bus.misses), 0);
    check_eq("arst_over", 32'(bus.game_over), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

`ifdef MOLE_NO_REPEAT_EN
    do_start();
    prev = '0;
    repeat (200) begin
      tick_pulse(1);
      cur = bus.mole;
      if (prev != '0) check_eq("no_repeat", 32'(cur == prev), 0);
      hit_lit();
      prev = cur;
    end
`endif

    cyc(5);
    check_eq("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
